// File: rtl/amp_preprocessor_seq_if.sv
// Frame request / result bundle for the serial note-amplitude floor stage.
// The master side issues frames and accepts results; the slave side is the DUT.
interface amp_preprocessor_seq_if #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12
);
  localparam int AW   = W + D;
  localparam int SUMW = AW + $clog2(BIN_QTY);
  localparam int IW   = $clog2(BIN_QTY);

  logic                         start;
  logic [BIN_QTY-1:0][AW-1:0]   noteAmplitudes_i;
  logic [D-1:0]                 floor_i;
  logic                         ready_i;
  logic                         busy_o;
  logic                         data_v;
  logic [BIN_QTY-1:0][AW-1:0]   noteAmplitudes_o;
  logic [BIN_QTY-1:0][AW-1:0]   noteAmplitudesFast_o;
  logic [SUMW-1:0]              amplitudeSumNew_o;
  logic [IW-1:0]                peakIdx_o;
  logic [AW-1:0]                peakVal_o;

  modport master (
    output start, noteAmplitudes_i, floor_i, ready_i,
    input  busy_o, data_v, noteAmplitudes_o, noteAmplitudesFast_o,
    input  amplitudeSumNew_o, peakIdx_o, peakVal_o
  );

  modport slave (
    input  start, noteAmplitudes_i, floor_i, ready_i,
    output busy_o, data_v, noteAmplitudes_o, noteAmplitudesFast_o,
    output amplitudeSumNew_o, peakIdx_o, peakVal_o
  );
endinterface

// File: rtl/amp_preprocessor_seq.sv
// Serial note-amplitude floor: sum, threshold, per-bin subtract/clamp.
// Define AMP_PREPROC_PEAK_EN to add peak-bin tracking during REDUCE.
module amp_preprocessor_seq #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int BIN_QTY = 12
) (
  input logic                    clk,
  input logic                    rst,
  amp_preprocessor_seq_if.slave  bus
);
  localparam int AW   = W + D;
  localparam int SUMW = AW + $clog2(BIN_QTY);
  localparam int IW   = $clog2(BIN_QTY);
  localparam int PW   = SUMW + D;

  typedef enum logic [2:0] {
    IDLE, SUM, THRESH, REDUCE, DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]              idx;
  logic [BIN_QTY-1:0][AW-1:0] amp_q;
  logic [D-1:0]               floor_q;
  logic [SUMW-1:0]            acc;
  logic [SUMW-1:0]            thr;
  logic [SUMW-1:0]            sum_new;
  logic [BIN_QTY-1:0][AW-1:0] red_q;
  logic [BIN_QTY-1:0][AW-1:0] fast_q;

  logic            last;
  logic [SUMW-1:0] amp_x;
  logic [SUMW-1:0] diff;
  logic            below;
  logic [AW-1:0]   red;
  logic [PW-1:0]   prod;

  assign last  = (idx == IW'(BIN_QTY - 1));
  assign amp_x = SUMW'(amp_q[idx]);
  assign below = (amp_x < thr);
  assign diff  = amp_x - thr;
  // amp >= thr here, so the difference always fits the amplitude width
  assign red   = below ? '0 : AW'(diff);
  assign prod  = PW'(acc) * PW'(floor_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start)   state_nx = SUM;
      SUM:     if (last)        state_nx = THRESH;
      THRESH:                   state_nx = REDUCE;
      REDUCE:  if (last)        state_nx = DONE;
      DONE:    if (bus.ready_i) state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      amp_q   <= '0;
      floor_q <= '0;
      acc     <= '0;
      thr     <= '0;
      sum_new <= '0;
      red_q   <= '0;
      fast_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          amp_q   <= bus.noteAmplitudes_i;
          floor_q <= bus.floor_i;
          acc     <= '0;
          idx     <= '0;
        end
        SUM: begin
          acc <= acc + amp_x;
          idx <= last ? '0 : idx + 1'b1;
        end
        THRESH: begin
          thr     <= SUMW'(prod >> D);
          sum_new <= '0;
          idx     <= '0;
        end
        REDUCE: begin
          red_q[idx]  <= red;
          fast_q[idx] <= below ? '0 : amp_q[idx];
          sum_new     <= sum_new + SUMW'(red);
          idx         <= last ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef AMP_PREPROC_PEAK_EN
  logic [IW-1:0] pk_idx;
  logic [AW-1:0] pk_val;

  // strict compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (rst || state == THRESH) begin
      pk_idx <= '0;
      pk_val <= '0;
    end else if (state == REDUCE && red > pk_val) begin
      pk_idx <= idx;
      pk_val <= red;
    end
  end

  assign bus.peakIdx_o = pk_idx;
  assign bus.peakVal_o = pk_val;
`else
  assign bus.peakIdx_o = '0;
  assign bus.peakVal_o = '0;
`endif

  assign bus.busy_o               = (state != IDLE);
  assign bus.data_v               = (state == DONE);
  assign bus.noteAmplitudes_o     = red_q;
  assign bus.noteAmplitudesFast_o = fast_q;
  assign bus.amplitudeSumNew_o    = sum_new;
endmodule

// File: tb/tb_amp_preprocessor_seq.sv
// Scoreboard bench for amp_preprocessor_seq: directed frames, queued
// expectations popped by a monitor on each result handshake.
module tb_amp_preprocessor_seq;
  localparam int W    = 6;
  localparam int D    = 10;
  localparam int N    = 12;
  localparam int AW   = W + D;
  localparam int SUMW = AW + $clog2(N);
  localparam int IW   = $clog2(N);

  typedef logic [N-1:0][AW-1:0] frame_t;

  typedef struct {
    string           nm;
    frame_t          red;
    frame_t          fast;
    logic [SUMW-1:0] sum;
    logic [IW-1:0]   pidx;
    logic [AW-1:0]   pval;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  amp_preprocessor_seq_if #(.W(W), .D(D), .BIN_QTY(N)) bus ();

  amp_preprocessor_seq #(.W(W), .D(D), .BIN_QTY(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: compare on every accepted result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.data_v && bus.ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_red"},  bus.noteAmplitudes_o,     e.red);
          chk({e.nm, "_fast"}, bus.noteAmplitudesFast_o, e.fast);
          chk({e.nm, "_sum"},  bus.amplitudeSumNew_o,    e.sum);
          chk({e.nm, "_pidx"}, bus.peakIdx_o,            e.pidx);
          chk({e.nm, "_pval"}, bus.peakVal_o,            e.pval);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send(frame_t f, logic [D-1:0] fl, bit push, exp_t e);
    @(posedge clk); #1;
    bus.start            = 1'b1;
    bus.noteAmplitudes_i = f;
    bus.floor_i          = fl;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.start            = 1'b0;
    bus.noteAmplitudes_i = {$urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom};
    bus.floor_i          = D'($urandom);
  endtask

  task automatic wait_dv();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.data_v) ok = 1;
    end
    if (!ok) chk("dv_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      if (!bus.busy_o) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_clear(string nm);
    chk({nm, "_busy"}, bus.busy_o,               0);
    chk({nm, "_dv"},   bus.data_v,               0);
    chk({nm, "_red"},  bus.noteAmplitudes_o,     0);
    chk({nm, "_fast"}, bus.noteAmplitudesFast_o, 0);
    chk({nm, "_sum"},  bus.amplitudeSumNew_o,    0);
    chk({nm, "_pidx"}, bus.peakIdx_o,            0);
    chk({nm, "_pval"}, bus.peakVal_o,            0);
  endtask

  frame_t f1, red1, fast1, fones, f6;
  exp_t   e1, e2, e3, e6;
  int     lat;

  initial begin
    f1    = {16'h0400, 16'h1000, 16'h1800, 16'h1000, 16'h1C00, 16'h0800,
             16'h0800, 16'h0800, 16'h0000, 16'h1400, 16'h2000, 16'h1C00};
    red1  = {16'h0000, 16'h0000, 16'h04E0, 16'h0000, 16'h08E0, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h00E0, 16'h0CE0, 16'h08E0};
    fast1 = {16'h0000, 16'h0000, 16'h1800, 16'h0000, 16'h1C00, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h1400, 16'h2000, 16'h1C00};
    fones = {N{16'hFFFF}};
    f6    = {16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400,
             16'h3000, 16'h0400, 16'h3000, 16'h0400, 16'h0400, 16'h0400};

`ifdef AMP_PREPROC_PEAK_EN
    e1 = '{"t1", red1, fast1, 20'd9312, 4'd1, 16'd3296};
    e2 = '{"t2", f1, f1, 20'd49152, 4'd1, 16'd8192};
    e6 = '{"t6", f6, f6, 20'd34816, 4'd3, 16'h3000};
`else
    e1 = '{"t1", red1, fast1, 20'd9312, 4'd0, 16'd0};
    e2 = '{"t2", f1, f1, 20'd49152, 4'd0, 16'd0};
    e6 = '{"t6", f6, f6, 20'd34816, 4'd0, 16'd0};
`endif
    e3 = '{"t3", '0, '0, 20'd0, 4'd0, 16'd0};

    bus.start            = 1'b0;
    bus.noteAmplitudes_i = '0;
    bus.floor_i          = '0;
    bus.ready_i          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_clear("reset");

    // test 1 with latency: accepting edge counts as edge 1
    send(f1, 10'h066, 1, e1);
    lat = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.data_v) break;
      @(posedge clk);
      lat++;
    end
    chk("t1_latency", lat, 26);
    wait_idle();

    send(f1, 10'h000, 1, e2);
    wait_idle();

    send(fones, 10'h3FF, 1, e3);
    wait_idle();

    // test 4: stall result, start pulse must be ignored
    @(posedge clk); #1 bus.ready_i = 1'b0;
    send(f1, 10'h066, 1, e1);
    wait_dv();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.start            = 1'b1;
        bus.noteAmplitudes_i = fones;
        bus.floor_i          = 10'h000;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk("t4_hold_dv",   bus.data_v,            1);
      chk("t4_hold_busy", bus.busy_o,            1);
      chk("t4_hold_red",  bus.noteAmplitudes_o,  red1);
      chk("t4_hold_sum",  bus.amplitudeSumNew_o, 20'd9312);
    end
    @(posedge clk); #1 bus.ready_i = 1'b1;
    @(posedge clk); #1;
    chk("t4_exit_busy", bus.busy_o, 0);
    chk("t4_exit_dv",   bus.data_v, 0);
    @(posedge clk); #1;
    chk("t4_still_idle", bus.busy_o, 0);

    // test 5: abort mid-SUM, then a clean frame
    send(fones, 10'h3FF, 0, e3);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_clear("t5_abort");
    send(f1, 10'h066, 1, e1);
    wait_idle();

    send(f6, 10'h000, 1, e6);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
